// File: rtl/daq_seq_pkg.sv
// Shared types and constants for the DAQ event sequencer.
// Latency: n/a (types, constants and word-building helpers only).
// Backpressure: n/a.
package daq_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DRAIN,
    ST_TRAILER
  } state_t;

  localparam logic [7:0] HDR_MARKER    = 8'h51;
  localparam int         TRL_TRUNC_BIT = 53;
  localparam int         TRL_TMO_BIT   = 52;
  localparam int         WC_W          = 20;

  function automatic logic [63:0] make_header(input logic [23:0] evt,
                                              input logic [11:0] board);
    return {HDR_MARKER, evt, 12'h000, board, 8'h00};
  endfunction

  function automatic logic [63:0] make_trailer(input logic [7:0]      evt_lo,
                                               input logic            trunc,
                                               input logic            tmo,
                                               input logic [WC_W-1:0] wc);
    logic [63:0] t;
    t                = '0;
    t[63:56]         = evt_lo;
    t[TRL_TRUNC_BIT] = trunc;
    t[TRL_TMO_BIT]   = tmo;
    t[51:32]         = wc;
    return t;
  endfunction

endpackage

// File: rtl/daq_word_packer.sv
// Packs 32-bit beats into 64-bit words (low half first), with zero-pad flush
// and a direct-load path for header/trailer words. Output is registered.
// Latency: 1 cycle from the completing beat / flush / load to word_vld_o.
// Backpressure: none internally; the caller only presents beats it accepted.
// Ports: beat_* (accepted beat + tlast), flush_i (emit pending half padded),
//        ld_* (emit a whole word), clear_i (drop pending half), word_* out.
module daq_word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        beat_vld_i,
  input  logic [31:0] beat_dat_i,
  input  logic        beat_last_i,
  input  logic        flush_i,
  input  logic        ld_vld_i,
  input  logic [63:0] ld_dat_i,
  output logic        half_o,
  output logic        word_vld_o,
  output logic [63:0] word_dat_o
);

  logic        half_q;
  logic [31:0] low_q;
  logic        vld_q;
  logic [63:0] dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      half_q <= 1'b0;
      low_q  <= '0;
      vld_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      vld_q <= 1'b0;
      if (ld_vld_i) begin
        vld_q  <= 1'b1;
        dat_q  <= ld_dat_i;
        half_q <= 1'b0;
      end else if (beat_vld_i) begin
        // A pending low half or an end-of-event beat completes a word.
        if (half_q || beat_last_i) begin
          vld_q  <= 1'b1;
          dat_q  <= half_q ? {beat_dat_i, low_q} : {32'h0, beat_dat_i};
          half_q <= 1'b0;
        end else begin
          low_q  <= beat_dat_i;
          half_q <= 1'b1;
        end
      end else if (flush_i && half_q) begin
        vld_q  <= 1'b1;
        dat_q  <= {32'h0, low_q};
        half_q <= 1'b0;
      end else if (clear_i) begin
        half_q <= 1'b0;
      end
    end
  end

  assign half_o     = half_q;
  assign word_vld_o = vld_q;
  assign word_dat_o = dat_q;

endmodule

// File: rtl/daq_event_sequencer.sv
// Per-trigger event framer: trigger pulse, header, packed payload, trailer.
// Latency: trigger -> chan_trigger_out/busy +1 cycle, header at +2 at best;
//          payload word 1 cycle after its completing beat.
// Backpressure: daq_almost_full stalls header/payload/trailer (tready drops);
//          DRAIN always accepts. Ports: trigger, AXIS slave, DAQ word/strobes,
//          status (busy, event_count, dropped_count).
module daq_event_sequencer
  import daq_seq_pkg::*;
#(
  parameter logic [11:0] BOARD_ID       = 12'h000,
  parameter int          MAX_WORDS      = 4096,
  parameter int          TIMEOUT_CYCLES = 125000
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic        trigger_in,
  output logic        chan_trigger_out,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] daq_data,
  output logic        daq_valid,
  output logic        daq_header,
  output logic        daq_trailer,
  input  logic        daq_ready,
  input  logic        daq_almost_full,
  output logic        busy,
  output logic [23:0] event_count,
  output logic [15:0] dropped_count
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q;
  logic              busy_q, chan_trig_q, hdr_q, trl_q, trunc_q, tmo_q;
  logic [23:0]       evt_q;
  logic [15:0]       drop_q;
  logic [WC_W-1:0]   wc_q;
  logic [IDLE_W-1:0] idle_q;

  logic        half, beat_acc, timeout_hit;
  logic        pk_beat, pk_flush, pk_ld;
  logic [63:0] pk_ld_dat;

  assign s_axis_tready = ((state_q == ST_PAYLOAD) && !daq_almost_full) ||
                         (state_q == ST_DRAIN);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;
  // idle_q counts completed beat-less cycles; this edge would be the Nth.
  assign timeout_hit   = !beat_acc && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    pk_beat   = beat_acc && (state_q == ST_PAYLOAD);
    // A half word left by a timeout goes out before the trailer.
    pk_flush  = (state_q == ST_TRAILER) && !daq_almost_full && half;
    pk_ld     = 1'b0;
    pk_ld_dat = '0;
    if ((state_q == ST_HEADER) && !daq_almost_full) begin
      pk_ld     = 1'b1;
      pk_ld_dat = make_header(evt_q, BOARD_ID);
    end else if ((state_q == ST_TRAILER) && !daq_almost_full && !half) begin
      pk_ld     = 1'b1;
      pk_ld_dat = make_trailer(evt_q[7:0], trunc_q, tmo_q, wc_q + 1'b1);
    end
  end

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      chan_trig_q <= 1'b0;
      hdr_q       <= 1'b0;
      trl_q       <= 1'b0;
      trunc_q     <= 1'b0;
      tmo_q       <= 1'b0;
      evt_q       <= '0;
      drop_q      <= '0;
      wc_q        <= '0;
      idle_q      <= '0;
    end else begin
      chan_trig_q <= 1'b0;
      hdr_q       <= 1'b0;
      trl_q       <= 1'b0;
      if (trigger_in && ((state_q != ST_IDLE) || !daq_ready) && (drop_q != 16'hFFFF))
        drop_q <= drop_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          trunc_q <= 1'b0;
          tmo_q   <= 1'b0;
          wc_q    <= '0;
          idle_q  <= '0;
          if (trigger_in && daq_ready) begin
            evt_q       <= evt_q + 1'b1;
            chan_trig_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (!daq_almost_full) begin
            hdr_q   <= 1'b1;
            wc_q    <= WC_W'(1);
            idle_q  <= '0;
            state_q <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (beat_acc) begin
            idle_q <= '0;
            if (half || s_axis_tlast) wc_q <= wc_q + 1'b1;
            if (s_axis_tlast) begin
              state_q <= ST_TRAILER;
            end else if (half && (wc_q == WC_W'(MAX_WORDS))) begin
              // wc_q still includes the header, so this word is payload #MAX_WORDS.
              trunc_q <= 1'b1;
              state_q <= ST_DRAIN;
            end
          end else if (timeout_hit) begin
            tmo_q   <= 1'b1;
            state_q <= ST_TRAILER;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (beat_acc) begin
            idle_q <= '0;
            if (s_axis_tlast) state_q <= ST_TRAILER;
          end else if (timeout_hit) begin
            tmo_q   <= 1'b1;
            state_q <= ST_TRAILER;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        ST_TRAILER: begin
          if (!daq_almost_full) begin
            wc_q <= wc_q + 1'b1;
            if (!half) begin
              trl_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  daq_word_packer u_packer (
    .clk_i       (clk125),
    .rst_i       (reset),
    .clear_i     (state_q == ST_IDLE),
    .beat_vld_i  (pk_beat),
    .beat_dat_i  (s_axis_tdata),
    .beat_last_i (s_axis_tlast),
    .flush_i     (pk_flush),
    .ld_vld_i    (pk_ld),
    .ld_dat_i    (pk_ld_dat),
    .half_o      (half),
    .word_vld_o  (daq_valid),
    .word_dat_o  (daq_data)
  );

  assign chan_trigger_out = chan_trig_q;
  assign daq_header       = hdr_q;
  assign daq_trailer      = trl_q;
  assign busy             = busy_q;
  assign event_count      = evt_q;
  assign dropped_count    = drop_q;

endmodule

// File: tb/tb_daq_event_sequencer.sv
// Testbench for daq_event_sequencer: table of events plus randomized events,
// each checked against a word-list model of the event framing rules.
module tb_daq_event_sequencer;

  localparam logic [11:0] BID  = 12'hA5C;
  localparam int          MAXW = 4;
  localparam int          TMO  = 100;

  logic        clk125 = 1'b0;
  logic        reset  = 1'b1;
  logic        trigger_in, chan_trigger_out;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [63:0] daq_data;
  logic        daq_valid, daq_header, daq_trailer, daq_ready, daq_almost_full, busy;
  logic [23:0] event_count;
  logic [15:0] dropped_count;

  always #4 clk125 = ~clk125;

  daq_event_sequencer #(.BOARD_ID(BID), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk125(clk125), .reset(reset), .trigger_in(trigger_in), .chan_trigger_out(chan_trigger_out),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .daq_data(daq_data), .daq_valid(daq_valid),
    .daq_header(daq_header), .daq_trailer(daq_trailer), .daq_ready(daq_ready),
    .daq_almost_full(daq_almost_full), .busy(busy), .event_count(event_count),
    .dropped_count(dropped_count)
  );

  typedef struct packed {logic [63:0] dat; logic hdr; logic trl;} word_t;
  typedef struct {int nb; bit tmo; int af_mode; bit trig_busy; int exp_wc; bit exp_trunc;} vec_t;

  int          n_chk = 0, n_fail = 0;
  longint      cyc = 0, trl_cyc = 0, last_beat_cyc = 0;
  logic        af_edge = 1'b0;
  word_t       got_q[$];
  logic [31:0] beats_q[$];
  logic [23:0] exp_evt = '0;
  logic [15:0] exp_drop = '0;
  vec_t        tbl[7];

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk125) begin
    cyc     <= cyc + 1;
    af_edge <= daq_almost_full;
  end

  // Capture every DAQ word; a word must never follow an edge with almost_full high.
  always @(negedge clk125) begin
    if (daq_valid && reset === 1'b0) begin
      got_q.push_back({daq_data, daq_header, daq_trailer});
      check("valid_after_af", 66'(af_edge), 66'd0);
      if (daq_trailer) trl_cyc = cyc;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk125);
      n++;
    end
    if (n >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_wait: busy still high after %0d cycles", n);
    end
  endtask

  task automatic run_event(input bit tmo_mode, input int af_mode, input bit trig_busy);
    int idx = 0, k = 0;
    bit acc;
    wait_idle();
    got_q.delete();
    @(negedge clk125);
    trigger_in = 1'b1;
    daq_ready  = 1'b1;
    @(negedge clk125);
    trigger_in = 1'b0;
    exp_evt    = exp_evt + 24'd1;
    check("chan_trig_pulse", 66'(chan_trigger_out), 66'd1);
    check("busy_after_trig", 66'(busy), 66'd1);
    while (idx < beats_q.size() && k < 2000) begin
      case (af_mode)
        1:       daq_almost_full = ($urandom_range(0, 3) == 0);
        2:       daq_almost_full = (k >= 3 && k <= 12);
        default: daq_almost_full = 1'b0;
      endcase
      s_axis_tvalid = (af_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tdata  = beats_q[idx];
      s_axis_tlast  = !tmo_mode && (idx == beats_q.size() - 1);
      trigger_in    = trig_busy && (k == 3);
      #1;
      if (af_mode == 2 && k >= 1)
        check("tready_vs_af", 66'(s_axis_tready), 66'(!daq_almost_full));
      acc = s_axis_tvalid && s_axis_tready;
      @(negedge clk125);
      if (acc) begin
        idx++;
        last_beat_cyc = cyc;
      end
      k++;
    end
    if (trig_busy) exp_drop = exp_drop + 16'd1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; daq_almost_full = 1'b0; trigger_in = 1'b0;
    if (k >= 2000) begin
      n_chk++; n_fail++;
      $display("FAIL beat_budget: only %0d of %0d beats accepted", idx, beats_q.size());
    end
    wait_idle();
    @(negedge clk125);
  endtask

  // Expected event: header, beat pairs (low first, odd tail zero padded,
  // capped at MAXW words), trailer counting every emitted word.
  task automatic compare_event(input bit tmo_mode);
    word_t       exp_q[$];
    word_t       e;
    int          nb, kept;
    bit          trunc;
    logic [19:0] nw;
    nb    = beats_q.size();
    kept  = (nb > 2 * MAXW) ? 2 * MAXW : nb;
    trunc = !tmo_mode && (nb > 2 * MAXW);
    e.dat = {8'h51, exp_evt, 12'h000, BID, 8'h00}; e.hdr = 1'b1; e.trl = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < kept; i += 2) begin
      e.dat[31:0]  = beats_q[i];
      e.dat[63:32] = (i + 1 < kept) ? beats_q[i + 1] : 32'h0;
      e.hdr = 1'b0; e.trl = 1'b0;
      exp_q.push_back(e);
    end
    nw    = 20'((kept + 1) / 2 + 2);
    e.dat = {exp_evt[7:0], 2'b00, trunc, tmo_mode, nw, 32'h0}; e.hdr = 1'b0; e.trl = 1'b1;
    exp_q.push_back(e);
    check("words_in_event", 66'(got_q.size()), 66'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("evt%0d_word%0d", exp_evt, i), got_q[i], exp_q[i]);
    check("event_count", 66'(event_count), 66'(exp_evt));
    check("dropped_count", 66'(dropped_count), 66'(exp_drop));
  endtask

  initial begin
    trigger_in = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    daq_ready = 1'b1; daq_almost_full = 1'b0;

    //            nb tmo af  tb  wc trunc
    tbl[0] = '{4,  0, 0,  0,  4, 0};
    tbl[1] = '{3,  0, 0,  0,  4, 0};
    tbl[2] = '{8,  0, 2,  0,  6, 0};
    tbl[3] = '{12, 0, 0,  0,  6, 1};
    tbl[4] = '{1,  1, 0,  0,  3, 0};
    tbl[5] = '{4,  0, 0,  1,  4, 0};
    tbl[6] = '{9,  0, 1,  0,  6, 1};

    repeat (2) @(negedge clk125);
    check("rst_busy", 66'(busy), 66'd0);
    check("rst_tready", 66'(s_axis_tready), 66'd0);
    check("rst_strobes", 66'({daq_valid, daq_header, daq_trailer, chan_trigger_out}), 66'd0);
    check("rst_counters", 66'({daq_data, event_count, dropped_count}), 66'd0);
    reset = 1'b0;
    @(negedge clk125);

    foreach (tbl[r]) begin
      beats_q.delete();
      for (int j = 0; j < tbl[r].nb; j++) beats_q.push_back((32'(r) << 16) | 32'(j + 1));
      run_event(tbl[r].tmo, tbl[r].af_mode, tbl[r].trig_busy);
      compare_event(tbl[r].tmo);
      if (got_q.size() > 0) begin
        check("trl_wc", 66'(got_q[$].dat[51:32]), 66'(tbl[r].exp_wc));
        check("trl_trunc", 66'(got_q[$].dat[53]), 66'(tbl[r].exp_trunc));
        check("trl_tmo", 66'(got_q[$].dat[52]), 66'(tbl[r].tmo));
      end
      if (tbl[r].tmo)
        check("tmo_gap_in_range", 66'(trl_cyc - last_beat_cyc >= TMO && trl_cyc - last_beat_cyc <= TMO + 10), 66'd1);
    end

    // Trigger while the link is not ready: dropped, no event started.
    wait_idle();
    @(negedge clk125);
    trigger_in = 1'b1; daq_ready = 1'b0;
    @(negedge clk125);
    trigger_in = 1'b0; daq_ready = 1'b1;
    exp_drop = exp_drop + 16'd1;
    check("no_pulse_not_ready", 66'(chan_trigger_out), 66'd0);
    check("idle_not_ready", 66'(busy), 66'd0);
    check("dropped_is_two", 66'(dropped_count), 66'd2);
    check("evt_unchanged", 66'(event_count), 66'(exp_evt));

    for (int n = 0; n < 25; n++) begin
      beats_q.delete();
      for (int j = 0; j < int'($urandom_range(1, 11)); j++) beats_q.push_back($urandom());
      run_event(1'b0, 1, 1'b0);
      compare_event(1'b0);
    end

    // Reset in the middle of a payload: everything clears without a clock edge.
    wait_idle();
    @(negedge clk125);
    trigger_in = 1'b1;
    @(negedge clk125);
    trigger_in = 1'b0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; s_axis_tdata = 32'hDEAD0001;
    repeat (4) @(negedge clk125);
    #2 reset = 1'b1;
    #1;
    check("amid_rst_busy_tready", 66'({busy, s_axis_tready}), 66'd0);
    check("amid_rst_strobes", 66'({daq_valid, daq_header, daq_trailer, chan_trigger_out}), 66'd0);
    check("amid_rst_data", 66'(daq_data), 66'd0);
    check("amid_rst_counters", 66'({event_count, dropped_count}), 66'd0);
    @(negedge clk125);
    s_axis_tvalid = 1'b0;
    reset = 1'b0;
    exp_evt = '0; exp_drop = '0;
    beats_q.delete();
    for (int j = 0; j < 4; j++) beats_q.push_back(32'(j + 1));
    run_event(1'b0, 0, 1'b0);
    compare_event(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
